apb_fifo_master: RTL and testbench
==================================

# apb_fifo_master

Single-clock APB requester on the APB side of the ICB-APB crypto bridge. It drains command words from the write-direction FIFO's read port and executes each one as one APB transfer. It then pushes one response word per transfer into the read-direction FIFO's write port. It is the reader of the WFIFO and the writer of the RFIFO, and it honours their empty/full flags and their pop/push strobes.

## Interface
- ADDR_W, 32, APB address width
- DATA_W, 32, APB data width
- TIMEOUT_CYC, 255, ACCESS-phase wait limit in cycles (used only with APB_TIMEOUT_EN, 1..255)

- clk  in  1  APB-domain clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_empty  in  1  WFIFO empty flag
- cmd_rdata_en  out  1  WFIFO pop strobe
- cmd_rdata  in  1+ADDR_W+DATA_W  {write, addr, wdata}; valid the cycle after the pop (registered FIFO read)
- rsp_full  in  1  RFIFO full flag
- rsp_wdata_vld  out  1  RFIFO push strobe
- rsp_wdata  out  1+DATA_W  {err, rdata}
- psel, penable, pwrite  out  1  APB control
- paddr  out  ADDR_W  APB address
- pwdata  out  DATA_W  APB write data
- pready, pslverr  in  1  APB completer status
- prdata  in  DATA_W  APB read data
- busy  out  1  high in every state except IDLE
- timeout_flag  out  1  sticky timeout indicator (present only with APB_TIMEOUT_EN)

## Operation
- FSM states: IDLE, FETCH, SETUP, ACCESS, RESP. Encoding is free.
- IDLE: when !cmd_empty && !rsp_full, assert cmd_rdata_en for exactly one cycle and go to FETCH. Otherwise stay in IDLE with cmd_rdata_en=0.
- FETCH: register cmd_rdata into pwrite, paddr and pwdata, then go to SETUP.
- SETUP: psel=1, penable=0, then go to ACCESS unconditionally.
- ACCESS: psel=1, penable=1.
  - pready=1: capture rsp_wdata = {pslverr, pwrite ? 0 : prdata} and go to RESP.
  - pready=0: stay in ACCESS.
- RESP: psel=0, penable=0. rsp_wdata_vld = !rsp_full, combinational from state. Leave for IDLE on the cycle the push occurs. Hold rsp_wdata while stalled.
- Every command yields exactly one response. A write response carries rdata=0.
- paddr, pwdata and pwrite stay stable from SETUP through the end of ACCESS. They are not cleared afterwards.
- At most one command is in flight, so there is never a second pop before the matching push.
- rsp_full is re-checked in RESP even though it was checked at issue, so the block stays correct if the RFIFO is shared.

## Timing
- Reset values: state IDLE; psel, penable, pwrite, cmd_rdata_en, rsp_wdata_vld, busy and timeout_flag are 0; paddr, pwdata and rsp_wdata are 0.
- Reset asserted mid-transfer: psel and penable drop asynchronously. The in-flight command is discarded and no response is pushed.
- Zero-wait transfer, with the pop in cycle 0 as t0:
  - t0: cmd_rdata_en=1
  - t0+1: FETCH
  - t0+2: SETUP
  - t0+3: ACCESS with pready=1
  - t0+4: RESP, push
  - t0+5: IDLE
  - Next pop at t0+5 at the earliest, giving a 5-cycle minimum per command.
- Each wait state (pready=0 in ACCESS) adds one cycle. Each cycle of rsp_full=1 in RESP adds one cycle.
- cmd_empty and rsp_full are sampled only in IDLE; rsp_full is also sampled in RESP.

## Configuration
- Macro APB_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to ACCESS and increments each ACCESS cycle with pready=0.
  - When the counter reaches TIMEOUT_CYC with pready still 0, go to RESP with rsp_wdata = {1, 0}.
  - timeout_flag sets and stays set until rst.
  - psel and penable are 0 in the following cycle.
- Undefined: the counter, the timeout_flag port and the timeout path are absent. ACCESS waits indefinitely for pready.

## Test plan
- Single read: push {0, 0x10, x} and have the completer return prdata=0xCAFEF00D with pready=1 and no waits -> one APB read at 0x10, with cmd_rdata_en at t0 and rsp_wdata_vld at t0+4 carrying {0, 0xCAFEF00D}.
- Write with 3 wait states: push {1, 0x24, 0x12345678} -> pwdata and paddr stable across 4 ACCESS cycles, then response {0, 0} at t0+7.
- Slave error: pslverr=1 on a read -> response {1, prdata}, then the FSM returns to IDLE.
- Backpressure: 4 queued commands with rsp_full held high for 10 cycles in RESP -> no further pop, rsp_wdata held stable, one push once rsp_full drops, exactly 4 responses in order.
- Reset mid-transfer: assert rst during ACCESS -> psel and penable go to 0 immediately, no response is pushed, and the next command after reset executes normally.
- APB_TIMEOUT_EN with TIMEOUT_CYC=16 and pready tied to 0 -> after 16 ACCESS cycles, response {1, 0}, timeout_flag=1, and the next command still executes.

Source files
------------

// File: rtl/apb_fifo_master_if.sv
// Port bundle for apb_fifo_master: WFIFO read port, RFIFO write port and APB requester.
// master = requester side, slave = FIFO/completer side.
interface apb_fifo_master_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic                   cmd_empty;
  logic                   cmd_rdata_en;
  logic [ADDR_W+DATA_W:0] cmd_rdata;
  logic                   rsp_full;
  logic                   rsp_wdata_vld;
  logic [DATA_W:0]        rsp_wdata;
  logic                   psel;
  logic                   penable;
  logic                   pwrite;
  logic [ADDR_W-1:0]      paddr;
  logic [DATA_W-1:0]      pwdata;
  logic                   pready;
  logic                   pslverr;
  logic [DATA_W-1:0]      prdata;

  modport master (
    input  cmd_empty, cmd_rdata, rsp_full, pready, pslverr, prdata,
    output cmd_rdata_en, rsp_wdata_vld, rsp_wdata, psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_empty, cmd_rdata, rsp_full, pready, pslverr, prdata,
    input  cmd_rdata_en, rsp_wdata_vld, rsp_wdata, psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_fifo_master.sv
// APB requester: pops {write, addr, wdata} commands, runs one APB transfer each, pushes {err, rdata}.
// Optional ACCESS-phase timeout enabled by defining APB_TIMEOUT_EN.
module apb_fifo_master #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
`ifdef APB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = 255
`endif
) (
  input  logic              clk,
  input  logic              rst,
  apb_fifo_master_if.master bus,
  output logic              busy
`ifdef APB_TIMEOUT_EN
  ,
  output logic              timeout_flag
`endif
);

  localparam int unsigned CMD_W = 1 + ADDR_W + DATA_W;
  localparam int unsigned RSP_W = 1 + DATA_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_e;

  state_e              state_q;
  logic                psel_q;
  logic                penable_q;
  logic                pwrite_q;
  logic [ADDR_W-1:0]   paddr_q;
  logic [DATA_W-1:0]   pwdata_q;
  logic [RSP_W-1:0]    rsp_wdata_q;
  logic                busy_q;
  logic                cmd_pop;
  logic                rsp_push;

`ifdef APB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0] wait_cnt_q;
  logic       timeout_q;
`endif

  // FIFO strobes are decoded from state so the pop/push land in the same cycle as the decision.
  assign cmd_pop  = !rst && (state_q == S_IDLE) && !bus.cmd_empty && !bus.rsp_full;
  assign rsp_push = !rst && (state_q == S_RESP) && !bus.rsp_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_wdata_q <= '0;
      busy_q      <= 1'b0;
`ifdef APB_TIMEOUT_EN
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_pop) begin
            state_q <= S_FETCH;
            busy_q  <= 1'b1;
          end
        end
        S_FETCH: begin
          pwrite_q <= bus.cmd_rdata[CMD_W-1];
          paddr_q  <= bus.cmd_rdata[ADDR_W+DATA_W-1:DATA_W];
          pwdata_q <= bus.cmd_rdata[DATA_W-1:0];
          psel_q   <= 1'b1;
          state_q  <= S_SETUP;
        end
        S_SETUP: begin
          penable_q <= 1'b1;
          state_q   <= S_ACCESS;
`ifdef APB_TIMEOUT_EN
          wait_cnt_q <= '0;
`endif
        end
        S_ACCESS: begin
          if (bus.pready) begin
            rsp_wdata_q <= {bus.pslverr, (pwrite_q ? {DATA_W{1'b0}} : bus.prdata)};
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            state_q     <= S_RESP;
          end
`ifdef APB_TIMEOUT_EN
          // Final unanswered wait cycle: abandon the transfer with an error response.
          else if (wait_cnt_q == TO_LAST) begin
            rsp_wdata_q <= {1'b1, {DATA_W{1'b0}}};
            timeout_q   <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            state_q     <= S_RESP;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
`endif
        end
        S_RESP: begin
          if (!bus.rsp_full) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_rdata_en  = cmd_pop;
  assign bus.rsp_wdata_vld = rsp_push;
  assign bus.rsp_wdata     = rsp_wdata_q;
  assign bus.psel          = psel_q;
  assign bus.penable       = penable_q;
  assign bus.pwrite        = pwrite_q;
  assign bus.paddr         = paddr_q;
  assign bus.pwdata        = pwdata_q;
  assign busy              = busy_q;
`ifdef APB_TIMEOUT_EN
  assign timeout_flag      = timeout_q;
`endif

endmodule

// File: tb/tb_apb_fifo_master.sv
// Bench for apb_fifo_master: queue-backed command FIFO, scripted APB completer, in-order scoreboard.
// Define APB_TIMEOUT_EN to also exercise the timeout path.
module tb_apb_fifo_master;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CMD_W  = 1 + ADDR_W + DATA_W;
  localparam int unsigned RSP_W  = 1 + DATA_W;
`ifdef APB_TIMEOUT_EN
  localparam int unsigned TO_CYC = 16;
`endif
  localparam int K_NORMAL  = 0;
  localparam int K_ABORT   = 1;
  localparam int K_TIMEOUT = 2;

  logic clk;
  logic rst;
  logic busy;
`ifdef APB_TIMEOUT_EN
  logic timeout_flag;
`endif

  apb_fifo_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  apb_fifo_master #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
`ifdef APB_TIMEOUT_EN
    ,
    .TIMEOUT_CYC(TO_CYC)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .busy(busy)
`ifdef APB_TIMEOUT_EN
    ,
    .timeout_flag(timeout_flag)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks, n_pass;
  int cyc, pops, pushes, last_pop_cyc;
  int acc_cyc, acc_instab, resp_instab, bad_pop;
  int wait_left, hold_left, full_mode;
  bit arm_hold, in_resp, in_flight, prev_access;
  logic cur_err;
  logic [DATA_W-1:0] cur_rdata;
  logic [CMD_W-1:0]  setup_cmd;
  logic [RSP_W-1:0]  resp_first;
  logic [CMD_W-1:0]  cmdq[$];
  logic [CMD_W-1:0]  exp_xfer[$];
  logic [CMD_W-1:0]  obs_xfer[$];
  logic [RSP_W-1:0]  exp_rsp[$];
  logic [RSP_W-1:0]  obs_rsp[$];
  int                plan_wait[$];
  logic              plan_err[$];
  logic [DATA_W-1:0] plan_rdata[$];
  int                lat_q[$];

  task automatic check_v(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_i(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Queue a command, script the completer's reply and record the expected outcome.
  task automatic add_cmd(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                         input int waits, input logic err, input logic [DATA_W-1:0] rd, input int kind);
    cmdq.push_back({wr, a, d});
    bus.cmd_empty = 1'b0;
    plan_wait.push_back(waits);
    plan_err.push_back(err);
    plan_rdata.push_back(rd);
    if (kind == K_NORMAL) begin
      exp_xfer.push_back({wr, a, d});
      exp_rsp.push_back({err, (wr ? {DATA_W{1'b0}} : rd)});
    end else if (kind == K_TIMEOUT) begin
      exp_rsp.push_back({1'b1, {DATA_W{1'b0}}});
    end
  endtask

  // One clock: observe at negedge, then update FIFO/completer/rsp_full just after posedge.
  task automatic tick();
    logic en, vld, ps, pe, pr;
    @(negedge clk);
    en  = bus.cmd_rdata_en;
    vld = bus.rsp_wdata_vld;
    ps  = bus.psel;
    pe  = bus.penable;
    pr  = bus.pready;
    if (rst) begin
      in_resp = 1'b0;
      in_flight = 1'b0;
      prev_access = 1'b0;
    end else begin
      if (en) begin
        pops++;
        last_pop_cyc = cyc;
        if (bus.rsp_full || bus.cmd_empty || in_flight) bad_pop++;
        in_flight = 1'b1;
      end
      if (ps && !pe) setup_cmd = {bus.pwrite, bus.paddr, bus.pwdata};
      if (ps && pe) begin
        acc_cyc++;
        if ({bus.pwrite, bus.paddr, bus.pwdata} !== setup_cmd) acc_instab++;
        if (pr) obs_xfer.push_back(setup_cmd);
      end
      if (prev_access && !ps && busy) begin
        in_resp = 1'b1;
        resp_first = bus.rsp_wdata;
      end
      if (in_resp && bus.rsp_wdata !== resp_first) resp_instab++;
      if (vld) begin
        obs_rsp.push_back(bus.rsp_wdata);
        pushes++;
        lat_q.push_back(cyc - last_pop_cyc);
        in_flight = 1'b0;
        in_resp = 1'b0;
      end
      prev_access = ps && pe;
    end
    @(posedge clk);
    cyc++;
    #1;
    if (en && cmdq.size() > 0) begin
      bus.cmd_rdata = cmdq.pop_front();
      bus.cmd_empty = (cmdq.size() == 0);
    end
    if (bus.psel && !bus.penable) begin
      if (plan_wait.size() > 0) begin
        wait_left = plan_wait.pop_front();
        cur_err   = plan_err.pop_front();
        cur_rdata = plan_rdata.pop_front();
      end else begin
        wait_left = 0;
        cur_err   = 1'b0;
        cur_rdata = DATA_W'($urandom);
      end
      bus.pready = 1'b0;
    end else if (bus.psel && bus.penable) begin
      if (wait_left > 0) begin
        wait_left--;
        bus.pready = 1'b0;
      end else begin
        bus.pready = 1'b1;
      end
    end else begin
      bus.pready = 1'b0;
    end
    bus.pslverr = bus.pready & cur_err;
    bus.prdata  = bus.pready ? cur_rdata : DATA_W'($urandom);
    if (full_mode == 1) begin
      bus.rsp_full = ($urandom_range(3) == 0);
    end else if (full_mode == 2) begin
      if (arm_hold && prev_access && !bus.psel && busy) begin
        hold_left = 10;
        arm_hold = 1'b0;
      end
      bus.rsp_full = (hold_left > 0);
      if (hold_left > 0) hold_left--;
    end else begin
      bus.rsp_full = 1'b0;
    end
  endtask

  task automatic run_until(input int target, input int budget, input string tag);
    int k;
    k = 0;
    while (pushes < target && k < budget) begin
      tick();
      k++;
    end
    check_i({tag, "_done"}, int'(pushes >= target), 1);
  endtask

  task automatic check_lat(input string tag, input int exp);
    int l;
    l = -1;
    if (lat_q.size() > 0) l = lat_q.pop_front();
    check_i({tag, "_latency"}, l, exp);
  endtask

  task automatic compare_all(input string tag);
    logic [RSP_W-1:0] ro, re;
    logic [CMD_W-1:0] xo, xe;
    check_i({tag, "_rsp_count"}, obs_rsp.size(), exp_rsp.size());
    while (obs_rsp.size() > 0 && exp_rsp.size() > 0) begin
      ro = obs_rsp.pop_front();
      re = exp_rsp.pop_front();
      check_v({tag, "_rsp"}, 128'(ro), 128'(re));
    end
    check_i({tag, "_xfer_count"}, obs_xfer.size(), exp_xfer.size());
    while (obs_xfer.size() > 0 && exp_xfer.size() > 0) begin
      xo = obs_xfer.pop_front();
      xe = exp_xfer.pop_front();
      check_v({tag, "_xfer"}, 128'(xo), 128'(xe));
    end
    obs_rsp.delete();
    exp_rsp.delete();
    obs_xfer.delete();
    exp_xfer.delete();
    lat_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, k;
    n_checks = 0; n_pass = 0; cyc = 0; pops = 0; pushes = 0; last_pop_cyc = 0;
    acc_cyc = 0; acc_instab = 0; resp_instab = 0; bad_pop = 0;
    wait_left = 0; hold_left = 0; full_mode = 0;
    arm_hold = 1'b0; in_resp = 1'b0; in_flight = 1'b0; prev_access = 1'b0;
    cur_err = 1'b0; cur_rdata = '0; setup_cmd = '0; resp_first = '0;
    rst = 1'b1;
    bus.cmd_empty = 1'b1;
    bus.cmd_rdata = '0;
    bus.rsp_full  = 1'b0;
    bus.pready    = 1'b0;
    bus.pslverr   = 1'b0;
    bus.prdata    = '0;
    #2;
    check_v("rst_psel",      128'(bus.psel), 128'(0));
    check_v("rst_penable",   128'(bus.penable), 128'(0));
    check_v("rst_pwrite",    128'(bus.pwrite), 128'(0));
    check_v("rst_paddr",     128'(bus.paddr), 128'(0));
    check_v("rst_pwdata",    128'(bus.pwdata), 128'(0));
    check_v("rst_rsp_wdata", 128'(bus.rsp_wdata), 128'(0));
    check_v("rst_pop",       128'(bus.cmd_rdata_en), 128'(0));
    check_v("rst_push",      128'(bus.rsp_wdata_vld), 128'(0));
    check_v("rst_busy",      128'(busy), 128'(0));
`ifdef APB_TIMEOUT_EN
    check_v("rst_timeout_flag", 128'(timeout_flag), 128'(0));
`endif
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Zero-wait read
    base = pops;
    add_cmd(1'b0, 32'h10, 32'h5A5A_0001, 0, 1'b0, 32'hCAFE_F00D, K_NORMAL);
    run_until(pushes + 1, 40, "rd0");
    repeat (3) tick();
    check_lat("rd0", 4);
    check_i("rd0_pops", pops - base, 1);
    compare_all("rd0");
    check_v("rd0_idle_busy", 128'(busy), 128'(0));

    // Write with three wait states
    acc_cyc = 0;
    add_cmd(1'b1, 32'h24, 32'h1234_5678, 3, 1'b0, 32'hFFFF_0000, K_NORMAL);
    run_until(pushes + 1, 40, "wr3");
    repeat (2) tick();
    check_lat("wr3", 7);
    check_i("wr3_access_cycles", acc_cyc, 4);
    check_i("wr3_addr_data_stable", acc_instab, 0);
    compare_all("wr3");

    // Slave error on a read
    add_cmd(1'b0, 32'h38, 32'h0000_0777, 1, 1'b1, 32'hDEAD_BEEF, K_NORMAL);
    run_until(pushes + 1, 40, "serr");
    repeat (2) tick();
    check_lat("serr", 5);
    compare_all("serr");
    check_v("serr_idle_busy", 128'(busy), 128'(0));
    check_v("serr_idle_psel", 128'(bus.psel), 128'(0));

    // Backpressure: first response held off for 10 cycles
    full_mode = 2;
    arm_hold = 1'b1;
    resp_instab = 0;
    add_cmd(1'b0, 32'h100, 32'h0, 0, 1'b0, 32'h1111_1111, K_NORMAL);
    add_cmd(1'b1, 32'h104, 32'hA5A5_A5A5, 0, 1'b0, 32'h2222_2222, K_NORMAL);
    add_cmd(1'b0, 32'h108, 32'h0, 0, 1'b1, 32'h3333_3333, K_NORMAL);
    add_cmd(1'b0, 32'h10C, 32'h0, 0, 1'b0, 32'h4444_4444, K_NORMAL);
    run_until(pushes + 4, 200, "bp");
    repeat (2) tick();
    check_lat("bp0", 14);
    check_lat("bp1", 4);
    check_lat("bp2", 4);
    check_lat("bp3", 4);
    check_i("bp_rsp_held", resp_instab, 0);
    check_i("bp_single_in_flight", bad_pop, 0);
    compare_all("bp");
    full_mode = 0;

    // Reset during ACCESS
    base = pushes;
    add_cmd(1'b0, 32'h44, 32'h0, 6, 1'b0, 32'h5555_5555, K_ABORT);
    k = 0;
    while (!(bus.psel && bus.penable) && k < 20) begin
      tick();
      k++;
    end
    check_v("rstmid_reached_access", 128'(bus.psel & bus.penable), 128'(1));
    tick();
    rst = 1'b1;
    #1;
    check_v("rstmid_psel",    128'(bus.psel), 128'(0));
    check_v("rstmid_penable", 128'(bus.penable), 128'(0));
    check_v("rstmid_busy",    128'(busy), 128'(0));
    repeat (3) tick();
    rst = 1'b0;
    repeat (3) tick();
    check_i("rstmid_no_push", pushes - base, 0);
    add_cmd(1'b1, 32'h48, 32'h0BAD_F00D, 2, 1'b0, 32'h6666_6666, K_NORMAL);
    run_until(pushes + 1, 40, "rstmid_next");
    repeat (2) tick();
    check_lat("rstmid_next", 6);
    compare_all("rstmid_next");

    // Randomised traffic with random response backpressure
    full_mode = 1;
    acc_instab = 0;
    resp_instab = 0;
    base = pushes;
    for (int i = 0; i < 40; i++) begin
      add_cmd(1'($urandom_range(1)), ADDR_W'($urandom), DATA_W'($urandom),
              int'($urandom_range(4)), ($urandom_range(7) == 0), DATA_W'($urandom), K_NORMAL);
      repeat ($urandom_range(6)) tick();
    end
    run_until(base + 40, 3000, "rand");
    full_mode = 0;
    repeat (3) tick();
    check_i("rand_addr_data_stable", acc_instab, 0);
    check_i("rand_rsp_held", resp_instab, 0);
    compare_all("rand");

`ifdef APB_TIMEOUT_EN
    // Completer never answers
    acc_cyc = 0;
    add_cmd(1'b0, 32'h200, 32'h0, 1000, 1'b0, 32'h7777_7777, K_TIMEOUT);
    run_until(pushes + 1, 80, "tmo");
    repeat (2) tick();
    check_lat("tmo", 19);
    check_i("tmo_access_cycles", acc_cyc, int'(TO_CYC));
    check_v("tmo_flag", 128'(timeout_flag), 128'(1));
    check_v("tmo_psel", 128'(bus.psel), 128'(0));
    compare_all("tmo");
    add_cmd(1'b0, 32'h204, 32'h0, 1, 1'b0, 32'h8888_8888, K_NORMAL);
    run_until(pushes + 1, 40, "tmo_next");
    repeat (2) tick();
    check_lat("tmo_next", 5);
    check_v("tmo_flag_sticky", 128'(timeout_flag), 128'(1));
    compare_all("tmo_next");
`endif

    check_i("pop_only_when_allowed", bad_pop, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
